// File: rtl/seq_mult_unit.sv
// ---------------------------------------------------------------------------
// seq_mult_unit
//   Sequential shift-add multiplier used by the ALU as its multiply resource.
//   The unit takes one ADD + SHIFT cycle pair per multiplier bit. In signed
//   mode it multiplies the magnitudes and negates the result at the end.
//   The product register holds its value from DONE until the next DONE.
//
// Parameters
//   WIDTH        operand width (>= 2); product is 2*WIDTH bits
//   CNT_W        iteration counter width (derived, do not override)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request, sampled only in IDLE
//   signed_mode  1 = two's-complement operands, latched with start
//   a_in, b_in   multiplicand / multiplier, latched with start
//   product      result, held from done until the next result
//   busy         high in ADD, SHIFT, DONE
//   done         one-cycle pulse in DONE
//   add/shr/incr debug step strobes (ADD / SHIFT / SHIFT)
// ---------------------------------------------------------------------------
module seq_mult_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done,
  output logic                 add,
  output logic                 shr,
  output logic                 incr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADD   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   m_reg;
  // P[2W:W] is the running partial sum (with carry), P[W-1:0] the multiplier.
  logic [2*WIDTH:0]   p_reg;
  logic               neg;

  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   p_shift;
  logic [2*WIDTH-1:0] p_low;
  logic [CNT_W-1:0]   cnt_inc;

  // Magnitude of the most-negative value wraps to 2^(W-1), which is exactly
  // the right unsigned magnitude, so no extra bit is needed.
  assign a_abs   = (signed_mode && a_in[WIDTH-1]) ? -a_in : a_in;
  assign b_abs   = (signed_mode && b_in[WIDTH-1]) ? -b_in : b_in;
  assign sum     = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + {1'b0, m_reg};
  assign p_shift = p_reg >> 1;
  assign p_low   = p_shift[2*WIDTH-1:0];
  assign cnt_inc = cnt + CNT_W'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too (not just the FSM) so the
      // product reads zero after reset and never shows stale or X content.
      state   <= S_IDLE;
      cnt     <= '0;
      m_reg   <= '0;
      p_reg   <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Operands are only captured on an accepted start, so X on the
          // inputs while idle cannot reach the registers.
          if (start) begin
            m_reg <= a_abs;
            p_reg <= {{(WIDTH+1){1'b0}}, b_abs};
            neg   <= signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
            cnt   <= '0;
            state <= S_ADD;
          end
        end
        S_ADD: begin
          if (p_reg[0]) begin
            p_reg[2*WIDTH:WIDTH] <= sum;
          end
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          p_reg <= p_shift;
          cnt   <= cnt_inc;
          if (cnt_inc < CNT_W'(WIDTH)) begin
            state <= S_ADD;
          end else begin
            // Final shift: load the result from the post-shift value.
            product <= neg ? -p_low : p_low;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign add  = (state == S_ADD);
  assign shr  = (state == S_SHIFT);
  assign incr = (state == S_SHIFT);

endmodule

// File: tb/tb_seq_mult_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_mult_unit
//   Directed bench for seq_mult_unit. It uses one 8-bit instance and one
//   32-bit (default width) instance. Each expected product is pushed to a
//   scoreboard queue when its start is driven. The bench pops and compares
//   that value when done is observed.
// ---------------------------------------------------------------------------
module tb_seq_mult_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start8, sm8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        busy8, done8, add8, shr8, incr8;

  logic        start32, sm32;
  logic [31:0] a32, b32;
  logic [63:0] p32;
  logic        busy32, done32, add32, shr32, incr32;

  seq_mult_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .a_in(a8), .b_in(b8), .product(p8), .busy(busy8), .done(done8),
    .add(add8), .shr(shr8), .incr(incr8)
  );

  seq_mult_unit dut32 (
    .clk(clk), .rst(rst), .start(start32), .signed_mode(sm32),
    .a_in(a32), .b_in(b32), .product(p32), .busy(busy32), .done(done32),
    .add(add32), .shr(shr32), .incr(incr32)
  );

  // Observation mux: sel32 picks which instance the tasks look at.
  logic        sel32 = 1'b0;
  logic        o_busy, o_done, o_add, o_shr, o_incr;
  logic [63:0] o_prod;
  assign o_busy = sel32 ? busy32 : busy8;
  assign o_done = sel32 ? done32 : done8;
  assign o_add  = sel32 ? add32  : add8;
  assign o_shr  = sel32 ? shr32  : shr8;
  assign o_incr = sel32 ? incr32 : incr8;
  assign o_prod = sel32 ? p32    : {48'b0, p8};

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb_q[$];
  logic [63:0] held8  = '0;
  logic [63:0] held32 = '0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference multiply: sign/zero-extend to 64 bits, multiply, truncate.
  function automatic logic [63:0] model(input bit w32, input bit sm,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ea, eb;
    if (w32) begin
      ea = sm ? {{32{a[31]}}, a} : {32'b0, a};
      eb = sm ? {{32{b[31]}}, b} : {32'b0, b};
      return ea * eb;
    end
    ea = sm ? {{56{a[7]}}, a[7:0]} : {56'b0, a[7:0]};
    eb = sm ? {{56{b[7]}}, b[7:0]} : {56'b0, b[7:0]};
    return (ea * eb) & 64'hFFFF;
  endfunction

  // The caller starts at #1 after an edge with the selected instance idle.
  // The task returns at #1 after the edge where the instance is idle again.
  task automatic run_op(input bit w32, input bit sm, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int          lim, lat, nbusy, nadd, nshr, nincr;
    bit          seen;
    logic [63:0] held, want;
    sel32 = w32;
    lim   = w32 ? 64 : 16;
    held  = w32 ? held32 : held8;
    sb_q.push_back(exp);
    if (w32) begin
      sm32 = sm; a32 = a; b32 = b; start32 = 1'b1;
    end else begin
      sm8 = sm; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
    end
    @(posedge clk); #1;
    start8 = 1'b0; start32 = 1'b0;
    // Operands are free to change once accepted.
    a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
    a32 = $urandom; b32 = $urandom; sm32 = 1'($urandom);
    check("accept_busy", 64'(o_busy), 64'd1);
    check("hold_at_accept", o_prod, held);
    nbusy = 1; nadd = int'(o_add); nshr = int'(o_shr); nincr = int'(o_incr);
    seen = 1'b0; lat = -1;
    for (int n = 1; n <= lim + 20 && !seen; n++) begin
      @(posedge clk); #1;
      if (o_busy) nbusy++;
      if (o_add)  nadd++;
      if (o_shr)  nshr++;
      if (o_incr) nincr++;
      if (o_done) begin
        seen = 1'b1;
        lat  = n;
      end
    end
    check("done_latency", 64'(lat), 64'(lim));
    want = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hDEAD;
    check("product", o_prod, want);
    check("add_count", 64'(nadd), 64'(lim / 2));
    check("shr_count", 64'(nshr), 64'(lim / 2));
    check("incr_count", 64'(nincr), 64'(lim / 2));
    @(posedge clk); #1;
    check("busy_cycles", 64'(nbusy), 64'(lim + 1));
    check("idle_after_done", {62'b0, o_busy, o_done}, 64'd0);
    check("product_held", o_prod, want);
    if (w32) held32 = want; else held8 = want;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int acc2, done1, done_cnt;
    bit prev_busy, seen;

    rst = 1'b1;
    start8 = 0; sm8 = 0; a8 = 0; b8 = 0;
    start32 = 0; sm32 = 0; a32 = 0; b32 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out8", {p8, 43'b0, busy8, done8, add8, shr8, incr8}, 64'd0);
    check("reset_prod32", p32, 64'd0);
    check("reset_ctl32", {59'b0, busy32, done32, add32, shr32, incr32}, 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // X on idle operands must not disturb anything.
    a8 = 'x; b8 = 'x; sm8 = 'x;
    repeat (3) @(posedge clk);
    #1;
    check("x_idle_busy", 64'(busy8), 64'd0);
    check("x_idle_prod", {48'b0, p8}, 64'd0);

    // Directed 8-bit cases.
    run_op(0, 0, 32'hFF, 32'hFF, 64'hFE01);
    run_op(0, 1, 32'hFD, 32'h05, 64'hFFF1);
    run_op(0, 1, 32'h80, 32'h80, 64'h4000);
    run_op(0, 1, 32'h80, 32'h01, 64'hFF80);
    run_op(0, 0, 32'h00, 32'hAA, 64'h0000);
    run_op(0, 0, 32'h37, 32'h00, 64'h0000);

    // Start held high: one accept per 18 cycles; operands changed while busy.
    sel32 = 1'b0;
    sm8 = 0; a8 = 8'd3; b8 = 8'd4; start8 = 1'b1;
    @(posedge clk); #1;
    sb_q.push_back(64'd12);
    a8 = 8'hAB; b8 = 8'h5C;
    prev_busy = 1'b1; acc2 = -1; done1 = -1; done_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done1 > 0 && n == done1 + 1)
        check("no_accept_in_done", 64'(busy8), 64'd0);
      if (done8) begin
        done_cnt++;
        if (done1 < 0) done1 = n;
        check("held_start_prod", {48'b0, p8},
              (sb_q.size() > 0) ? sb_q.pop_front() : 64'hDEAD);
        a8 = 8'd3; b8 = 8'd4;
      end
      if (busy8 && !prev_busy) begin
        if (acc2 < 0) acc2 = n;
        sb_q.push_back(64'd12);
        a8 = 8'hE7; b8 = 8'h19;
      end
      prev_busy = busy8;
    end
    start8 = 1'b0;
    check("held_first_done", 64'(done1), 64'd16);
    check("held_second_accept", 64'(acc2), 64'd18);
    check("held_done_count", 64'(done_cnt), 64'd2);
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(posedge clk); #1;
      if (done8) seen = 1'b1;
    end
    check("held_drain_done", 64'(seen), 64'd1);
    check("held_drain_prod", {48'b0, p8},
          (sb_q.size() > 0) ? sb_q.pop_front() : 64'hDEAD);
    @(posedge clk); #1;
    held8 = 64'd12;

    // Asynchronous reset mid-operation.
    sm8 = 0; a8 = 8'd10; b8 = 8'd20; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_ctl", {59'b0, busy8, done8, add8, shr8, incr8}, 64'd0);
    check("async_rst_prod", {48'b0, p8}, 64'd0);
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done8) seen = 1'b1;
    end
    check("no_done_in_reset", 64'(seen), 64'd0);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done8 || busy8) seen = 1'b1;
    end
    check("no_done_after_reset", 64'(seen), 64'd0);
    held8 = 64'd0;
    run_op(0, 0, 32'd10, 32'd20, 64'd200);

    // Random 8-bit operands, both modes, against the reference model.
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      bit          rs;
      ra = $urandom;
      rb = $urandom;
      rs = i[0];
      run_op(0, rs, ra, rb, model(0, rs, ra, rb));
    end

    // Default 32-bit width.
    run_op(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      run_op(1, 0, ra, rb, model(1, 0, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_unit.md
Name: seq_mult_unit

Overview:
- Parametrised sequential shift-add multiplier: control FSM, iteration counter and datapath in one block.
- Adds selectable signed/unsigned mode, a start/busy/done handshake and a held product register.
- Sits under the ALU as the multiply resource. The ALU drives operands plus a one-cycle start and waits for done.
- Also exports add/shr/incr step strobes for debug and trace.

Parameters:
- WIDTH, 32, operand width in bits; legal ≥ 2; product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; latched with start.
- a_in  input  WIDTH  multiplicand; latched with start.
- b_in  input  WIDTH  multiplier; latched with start.
- product  output  2*WIDTH  result; held from done until the next accepted start.
- busy  output  1  high in ADD, SHIFT, DONE.
- done  output  1  one-cycle pulse, high in DONE.
- add  output  1  high in ADD.
- shr  output  1  high in SHIFT.
- incr  output  1  high in SHIFT (counter increments).

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, internal registers=0, product=0; busy, done, add, shr and incr all 0. Reset mid-operation discards the operation; no done is produced.
- States and transitions:
  - IDLE: start=1 → ADD. Otherwise stay.
  - ADD → SHIFT, unconditionally.
  - SHIFT: counter+1 < WIDTH → ADD. Otherwise → DONE.
  - DONE → IDLE.
- Accept, at the clock edge where start=1 in IDLE:
  - M = |a_in| if signed_mode else a_in. Q = |b_in| if signed_mode else b_in.
  - neg = signed_mode & (a_in[MSB] ^ b_in[MSB]).
  - P[2W:0] = {(W+1)'b0, Q}. counter=0.
  - |x| of the most-negative value is 2^(W-1) and fits W unsigned bits.
- ADD: if P[0]=1, P[2W:W] = P[2W-1:W] + M, with the carry kept in P[2W]. If P[0]=0, P is unchanged. The add strobe is high either way.
- SHIFT: P = P >> 1 (logical; zero enters P[2W]); counter+1.
- Entry to DONE, on the final SHIFT edge: product is loaded with neg ? -(P_shifted[2W-1:0]) : P_shifted[2W-1:0], using the post-shift P.
  - -2^(W-1) × -2^(W-1) = 2^(2W-2) fits with no overflow.
- Latency: with start sampled at edge E0, done is high in the cycle after edge E(2*WIDTH), and product is valid in that same cycle. The FSM returns to IDLE at E(2*WIDTH+1). Throughput is one multiply per 2*WIDTH+2 cycles.
- start while busy (ADD, SHIFT or DONE) is ignored. No queueing. Operands may change freely after acceptance.
- start is first honoured in the IDLE cycle after DONE.
- product is not modified between DONE and the next accept edge. At the accept edge product keeps its old value until the new DONE.
- Zero operands take the full latency; there is no early termination.
- No X propagation from operand inputs while IDLE and start=0.

Test Plan:
- WIDTH=8, unsigned, a=255, b=255, one-cycle start → done high exactly 16 edges after start edge, product=0xFE01. busy high for 17 cycles. add/shr alternate 8 times each.
- WIDTH=8, signed, a=0xFD (-3), b=0x05 → product=0xFFF1 (-15). Then a=0x80, b=0x80 → product=0x4000. Then a=0x80, b=0x01 → product=0xFF80.
- WIDTH=8, unsigned, a=0, b=0xAA and a=0x37, b=0 → product=0x0000, done still at 16 edges.
- Start held high continuously, a=3, b=4 → exactly one operation per 18 cycles.
  - Operand changes on a_in/b_in during busy are ignored; each result is 12.
  - The start during DONE is not accepted. The next accept occurs in the following IDLE cycle.
- Assert rst asynchronously (between edges) 5 cycles into an operation → outputs zero immediately, no done pulse. A new start after release yields a correct product (a=10, b=20 → 200).
- WIDTH=32 default: signed a=0x80000000, b=0xFFFFFFFF → product=0x0000000080000000, done 64 edges after start.
